// File: rtl/palette_mapper.sv
// Palette lookup: two-stage pixel-to-colour pipeline over a writable palette with a
// reload sweep back to the default palette. Define PALETTE_READBACK_EN for the rd_addr_i/rd_data_o port.
module palette_mapper #(
    parameter int NUM_WIDTH   = 4,
    parameter int COLOR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid_i,
    input  logic [NUM_WIDTH-1:0]   pix_num_i,
    input  logic                   pix_blank_i,
    output logic [COLOR_WIDTH-1:0] color_o,
    output logic                   color_valid_o,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [NUM_WIDTH-1:0]   wr_addr_i,
    input  logic [COLOR_WIDTH-1:0] wr_data_i,
    input  logic                   reload_i,
`ifdef PALETTE_READBACK_EN
    input  logic [NUM_WIDTH-1:0]   rd_addr_i,
    output logic [COLOR_WIDTH-1:0] rd_data_o,
`endif
    output logic                   busy_o
);

    localparam int DEPTH = 2 ** NUM_WIDTH;

    typedef enum logic [0:0] {IDLE, RELOAD} state_e;

    state_e                 state_q, state_d;
    logic [NUM_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   busy_q, busy_d;
    logic [COLOR_WIDTH-1:0] pal_q [DEPTH];
    logic [COLOR_WIDTH-1:0] pal_d [DEPTH];
    logic                   valid_s1_q, valid_s1_d;
    logic [NUM_WIDTH-1:0]   num_s1_q, num_s1_d;
    logic                   blank_s1_q, blank_s1_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   color_valid_q, color_valid_d;

    // Sweep control: the accepted write and the reload request may share an edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (reload_i) begin
                    state_d = RELOAD;
                    cnt_d   = '0;
                end
            end
            RELOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ready_d = (state_d == IDLE);
        busy_d     = (state_d == RELOAD);
    end

    always_comb begin
        pal_d = pal_q;
        if (wr_valid_i && wr_ready_q) begin
            pal_d[wr_addr_i] = wr_data_i;
        end
        if (state_q == RELOAD) begin
            pal_d[cnt_q] = (cnt_q == '1) ? '1 : '0;
        end
    end

    // Stage 2 reads pal_q one edge after the pixel was sampled, so it already holds
    // every write accepted at the sampling edge.
    always_comb begin
        valid_s1_d    = pix_valid_i;
        num_s1_d      = pix_num_i;
        blank_s1_d    = pix_blank_i;
        color_valid_d = valid_s1_q;
        color_d       = (valid_s1_q && !blank_s1_q) ? pal_q[num_s1_q] : '0;
    end

    // NOTE: the palette is a flop array rather than a RAM because reset must restore
    // every entry at once; each element gets its default in the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            valid_s1_q    <= 1'b0;
            num_s1_q      <= '0;
            blank_s1_q    <= 1'b0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pal_q[i] <= (i == DEPTH - 1) ? '1 : '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ready_q    <= wr_ready_d;
            busy_q        <= busy_d;
            valid_s1_q    <= valid_s1_d;
            num_s1_q      <= num_s1_d;
            blank_s1_q    <= blank_s1_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            pal_q         <= pal_d;
        end
    end

`ifdef PALETTE_READBACK_EN
    logic [COLOR_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = pal_d[rd_addr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
`endif

    assign color_o       = color_q;
    assign color_valid_o = color_valid_q;
    assign wr_ready_o    = wr_ready_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_palette_mapper.sv
// Directed bench for palette_mapper: pixel pipeline, write bypass, blanking, reload sweep,
// reset mid-sweep and (with PALETTE_READBACK_EN) the readback port.
module tb_palette_mapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid_i, pix_blank_i;
    logic [3:0] pix_num_i;
    logic [7:0] color_o;
    logic       color_valid_o;
    logic       wr_valid_i, wr_ready_o;
    logic [3:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       reload_i, busy_o;
`ifdef PALETTE_READBACK_EN
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    palette_mapper #(.NUM_WIDTH(4), .COLOR_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid_i   (pix_valid_i),
        .pix_num_i     (pix_num_i),
        .pix_blank_i   (pix_blank_i),
        .color_o       (color_o),
        .color_valid_o (color_valid_o),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .reload_i      (reload_i),
`ifdef PALETTE_READBACK_EN
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] addr, input logic [7:0] data);
        wr_valid_i = 1'b1;
        wr_addr_i  = addr;
        wr_data_i  = data;
        step();
        wr_valid_i = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [3:0] num, input logic [7:0] exp);
        pix_valid_i = 1'b1;
        pix_num_i   = num;
        step();
        pix_valid_i = 1'b0;
        step();
        check({tag, "_color"}, color_o, exp);
        check({tag, "_valid"}, color_valid_o, 1'b1);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        pix_valid_i = 1'b0;
        pix_blank_i = 1'b0;
        pix_num_i   = '0;
        wr_valid_i  = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        reload_i    = 1'b0;
`ifdef PALETTE_READBACK_EN
        rd_addr_i   = '0;
`endif
        repeat (3) step();
        check("rst_color", color_o, 8'h00);
        check("rst_valid", color_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
`ifdef PALETTE_READBACK_EN
        check("rst_rd_data", rd_data_o, 8'h00);
`endif
        rst_n = 1'b1;
        step();
        check("post_rst_ready", wr_ready_o, 1'b1);

        // Back-to-back pixels 0x0, 0xF, 0x7 on the default palette.
        pix_valid_i = 1'b1;
        pix_num_i   = 4'h0;
        step();
        check("pipe_e1_valid", color_valid_o, 1'b0);
        pix_num_i = 4'hF;
        step();
        check("pipe_p0_color", color_o, 8'h00);
        check("pipe_p0_valid", color_valid_o, 1'b1);
        pix_num_i = 4'h7;
        step();
        check("pipe_pF_color", color_o, 8'hFF);
        pix_valid_i = 1'b0;
        step();
        check("pipe_p7_color", color_o, 8'h00);
        check("pipe_p7_valid", color_valid_o, 1'b1);
        step();
        check("pipe_idle_valid", color_valid_o, 1'b0);
        check("pipe_idle_color", color_o, 8'h00);

        // Write and lookup of the same entry sampled on one edge.
        wr_valid_i  = 1'b1;
        wr_addr_i   = 4'h3;
        wr_data_i   = 8'hE0;
        pix_valid_i = 1'b1;
        pix_num_i   = 4'h3;
        step();
        wr_valid_i  = 1'b0;
        pix_valid_i = 1'b0;
        step();
        check("bypass_color", color_o, 8'hE0);
        check("bypass_valid", color_valid_o, 1'b1);

        pix_blank_i = 1'b1;
        lookup("blank", 4'hF, 8'h00);
        pix_blank_i = 1'b0;
        lookup("unblank", 4'hF, 8'hFF);

        // Fill the palette with 0x5A, then reload; a second reload mid-sweep is ignored.
        for (int i = 0; i < 16; i++) write(4'(i), 8'h5A);
        lookup("fill_e", 4'hE, 8'h5A);
        lookup("fill_f", 4'hF, 8'h5A);
        reload_i = 1'b1;
        step();
        reload_i = 1'b0;
        n = 0;
        while (busy_o === 1'b1 && n < 40) begin
            check("sweep_ready_low", wr_ready_o, 1'b0);
            reload_i = (n == 8);
            step();
            n++;
        end
        reload_i = 1'b0;
        check("sweep_cycles", n, 16);
        check("sweep_ready_back", wr_ready_o, 1'b1);
        lookup("reload_0", 4'h0, 8'h00);
        lookup("reload_3", 4'h3, 8'h00);
        lookup("reload_e", 4'hE, 8'h00);
        lookup("reload_f", 4'hF, 8'hFF);

        // Reset partway through a sweep.
        write(4'hE, 8'h5A);
        write(4'hF, 8'h00);
        lookup("pre_abort_e", 4'hE, 8'h5A);
        reload_i = 1'b1;
        step();
        reload_i = 1'b0;
        repeat (5) step();
        check("abort_busy_before", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", color_valid_o, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_ready", wr_ready_o, 1'b1);
        lookup("abort_e", 4'hE, 8'h00);
        lookup("abort_f", 4'hF, 8'hFF);

`ifdef PALETTE_READBACK_EN
        rd_addr_i = 4'h2;
        write(4'h2, 8'h1C);
        check("readback_bypass", rd_data_o, 8'h1C);
        rd_addr_i = 4'hF;
        step();
        check("readback_f", rd_data_o, 8'hFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
